// File: rtl/rop_detector_pkg.sv
// ---------------------------------------------------------------------------
// rop_pkg
//   Shared types and constants for the ROP shadow-stack monitor.
//   CALL_OFS / RET_OFS : low three offset bits that mark a trampoline
//                        CALL slot and a trampoline RET slot.
//   addr_t / slot_t    : branch-target address and stored slot index.
//   kind_e             : classification of one sampled branch target.
// ---------------------------------------------------------------------------
package rop_pkg;

   localparam int unsigned ADDR_BITS = 32;
   localparam int unsigned SLOT_BITS = 29;

   localparam logic [2:0] CALL_OFS = 3'd0;
   localparam logic [2:0] RET_OFS  = 3'd4;

   typedef logic [ADDR_BITS-1:0] addr_t;
   typedef logic [SLOT_BITS-1:0] slot_t;

   typedef enum logic [1:0] {
      K_DJMP,
      K_CALL,
      K_RET,
      K_BAD
   } kind_e;

endpackage

// File: rtl/rop_shadow_stack.sv
// ---------------------------------------------------------------------------
// rop_shadow_stack
//   Synchronous LIFO holding trampoline slot indices.
//   iClk   : clock, rising edge
//   iRsn   : asynchronous active-low reset (empties the stack)
//   iPush  : push iData (ignored when full)
//   iPop   : discard the top entry (ignored when empty)
//   iData  : entry to push
//   oEmpty : no entries held
//   oFull  : DEPTH entries held
//   oTop   : most recently pushed entry (meaningless while empty)
// ---------------------------------------------------------------------------
module rop_shadow_stack #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned W     = 29
)(
   input  logic         iClk,
   input  logic         iRsn,
   input  logic         iPush,
   input  logic         iPop,
   input  logic [W-1:0] iData,
   output logic         oEmpty,
   output logic         oFull,
   output logic [W-1:0] oTop
);

   localparam int unsigned PW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] r_sp;
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] w_top_idx;
   logic          w_do_push;
   logic          w_do_pop;

   always_comb begin
      oEmpty    = (r_sp == '0);
      oFull     = (r_sp == PW'(DEPTH));
      w_top_idx = AW'(r_sp - PW'(1));
      oTop      = r_mem[w_top_idx];
      w_do_push = iPush && !oFull && !iPop;
      w_do_pop  = iPop && !oEmpty;
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         r_sp <= '0;
      end else if (w_do_push) begin
         r_sp <= r_sp + PW'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - PW'(1);
      end
   end

   // Storage needs no reset: entries are only read below the pointer.
   always_ff @(posedge iClk) begin
      if (w_do_push) begin
         r_mem[r_sp[AW-1:0]] <= iData;
      end
   end

endmodule

// File: rtl/rop_detector.sv
// ---------------------------------------------------------------------------
// rop_detector
//   Shadow-stack monitor for return-oriented-programming attacks. Pops
//   branch targets from a trace FIFO, classifies each as trampoline CALL,
//   trampoline RET, misaligned trampoline target or direct jump, and pulses
//   an alarm on unmatched returns, stack overflow or misaligned targets.
//   iClk              : clock, rising edge
//   iRsn              : asynchronous active-low reset
//   iTRAMPOLINE_START : first byte address of trampoline region
//   iTRAMPOLINE_END   : last valid address of trampoline region (inclusive)
//   iFifo_Data        : branch target, valid the cycle after oFifo_RdEn
//   iFifo_Empty       : FIFO holds no data
//   oFifo_RdEn        : FIFO pop request
//   oRopDetect        : one-cycle alarm pulse
// ---------------------------------------------------------------------------
module rop_detector
   import rop_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 32,
   parameter int unsigned SLOT_W      = rop_pkg::SLOT_BITS
)(
   input  logic        iClk,
   input  logic        iRsn,
   input  logic [31:0] iTRAMPOLINE_START,
   input  logic [31:0] iTRAMPOLINE_END,
   input  logic [31:0] iFifo_Data,
   input  logic        iFifo_Empty,
   output logic        oFifo_RdEn,
   output logic        oRopDetect
);

   logic              r_rd_vld;
   logic              r_alarm;

   addr_t             w_off;
   logic [SLOT_W-1:0] w_slot;
   kind_e             w_kind;
   logic              w_push;
   logic              w_pop;
   logic              w_alarm;
   logic              w_empty;
   logic              w_full;
   logic [SLOT_W-1:0] w_top;

   assign oFifo_RdEn = iRsn & ~iFifo_Empty;
   assign oRopDetect = r_alarm;

   // Classification of the address presented this cycle, against the
   // bounds presented in the same cycle.
   always_comb begin
      w_off  = iFifo_Data - iTRAMPOLINE_START;
      w_slot = w_off[3 +: SLOT_W];
      if ((iFifo_Data < iTRAMPOLINE_START) || (iFifo_Data > iTRAMPOLINE_END)) begin
         w_kind = K_DJMP;
      end else begin
         case (w_off[2:0])
            CALL_OFS: w_kind = K_CALL;
            RET_OFS:  w_kind = K_RET;
            default:  w_kind = K_BAD;
         endcase
      end
   end

   // Stack actions and alarm; only meaningful while the FIFO data is valid.
   // A mismatching RET still pops so later nesting stays balanced.
   always_comb begin
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_alarm = 1'b0;
      if (r_rd_vld) begin
         case (w_kind)
            K_CALL: begin
               if (w_full) w_alarm = 1'b1;
               else        w_push  = 1'b1;
            end
            K_RET: begin
               w_pop   = !w_empty;
               w_alarm = w_empty || (w_top != w_slot);
            end
            K_BAD:   w_alarm = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         r_rd_vld <= 1'b0;
         r_alarm  <= 1'b0;
      end else begin
         r_rd_vld <= oFifo_RdEn;
         r_alarm  <= w_alarm;
      end
   end

   rop_shadow_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (SLOT_W)
   ) u_stack (
      .iClk   (iClk),
      .iRsn   (iRsn),
      .iPush  (w_push),
      .iPop   (w_pop),
      .iData  (w_slot),
      .oEmpty (w_empty),
      .oFull  (w_full),
      .oTop   (w_top)
   );

endmodule

// File: tb/tb_rop_detector.sv
module tb_rop_detector;

   typedef struct {
      logic [31:0] a;
      logic [31:0] s;
      logic [31:0] e;
      bit          exp;
   } vec_t;

   logic        iClk;
   logic        iRsn;
   logic [31:0] iTRAMPOLINE_START;
   logic [31:0] iTRAMPOLINE_END;
   logic [31:0] iFifo_Data;
   logic        iFifo_Empty;
   logic        oFifo_RdEn;
   logic        oRopDetect;

   vec_t fifo_q[$];
   vec_t exp_q[$];

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   bit          drv_en = 0;
   bit          stall_en = 0;

   rop_detector #(
      .STACK_DEPTH (32),
      .SLOT_W      (29)
   ) dut (
      .iClk              (iClk),
      .iRsn              (iRsn),
      .iTRAMPOLINE_START (iTRAMPOLINE_START),
      .iTRAMPOLINE_END   (iTRAMPOLINE_END),
      .iFifo_Data        (iFifo_Data),
      .iFifo_Empty       (iFifo_Empty),
      .oFifo_RdEn        (oFifo_RdEn),
      .oRopDetect        (oRopDetect)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic push_vec(input logic [31:0] a, input logic [31:0] s,
                           input logic [31:0] e, input bit exp);
      vec_t v;
      v.a = a; v.s = s; v.e = e; v.exp = exp;
      fifo_q.push_back(v);
      exp_q.push_back(v);
   endtask

   // FIFO model: data and bounds appear the cycle after a RdEn cycle;
   // in every other cycle the data bus carries junk.
   initial begin : fifo_drv
      vec_t v;
      wait (drv_en);
      forever begin
         @(posedge iClk);
         if (oFifo_RdEn && fifo_q.size() > 0) begin
            v = fifo_q.pop_front();
            #1;
            iFifo_Data        = v.a;
            iTRAMPOLINE_START = v.s;
            iTRAMPOLINE_END   = v.e;
         end else begin
            #1;
            iFifo_Data = $urandom;
         end
         @(negedge iClk);
         iFifo_Empty = (fifo_q.size() == 0) ||
                       (stall_en && ($urandom_range(0, 3) == 0));
      end
   end

   // Monitor: the alarm for the address read in RdEn cycle N is visible
   // in cycle N+2; every other cycle must show no alarm.
   initial begin : mon
      bit   h1, h2;
      vec_t v;
      h1 = 0; h2 = 0;
      forever begin
         @(posedge iClk);
         h2 = h1;
         h1 = oFifo_RdEn;
         @(negedge iClk);
         if (h2) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_underflow got read with no expectation want expectation");
            end else begin
               v = exp_q.pop_front();
               if (oRopDetect !== v.exp) begin
                  n_fail++;
                  $display("FAIL alarm addr=%h start=%h end=%h got %b want %b",
                           v.a, v.s, v.e, oRopDetect, v.exp);
               end
            end
         end else if (oRopDetect !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_alarm t=%0t got %b want 0", $time, oRopDetect);
         end
      end
   end

   task automatic check_now(input string name, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   task automatic drain(input string name);
      int unsigned cyc;
      cyc = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
         @(posedge iClk);
         cyc++;
      end
      repeat (4) @(posedge iClk);
      n_cmp++;
      if (fifo_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_%s got %0d/%0d pending want 0/0", name,
                  fifo_q.size(), exp_q.size());
      end
   endtask

   localparam logic [31:0] B  = 32'h8000_0000;
   localparam logic [31:0] E  = 32'h8000_0024;
   localparam logic [31:0] B2 = 32'h8000_0040;
   localparam logic [31:0] E2 = 32'h8000_0064;
   localparam logic [31:0] EB = 32'h8000_01FF;

   initial begin : main
      iRsn = 1'b0;
      iFifo_Empty = 1'b0;
      iFifo_Data = '0;
      iTRAMPOLINE_START = B;
      iTRAMPOLINE_END = E;
      #3;
      check_now("rst_rden_gated", oFifo_RdEn, 1'b0);
      check_now("rst_alarm", oRopDetect, 1'b0);
      iFifo_Empty = 1'b1;
      repeat (2) @(negedge iClk);
      iRsn = 1'b1;
      repeat (3) begin
         @(negedge iClk);
         check_now("idle_rden", oFifo_RdEn, 1'b0);
         check_now("idle_alarm", oRopDetect, 1'b0);
      end
      drv_en = 1;

      // Balanced nesting with a direct jump in between; closing empty RET.
      push_vec(32'h8000_0008, B, E, 0);
      push_vec(32'h0000_1234, B, E, 0);
      push_vec(32'h8000_0010, B, E, 0);
      push_vec(32'h8000_0014, B, E, 0);
      push_vec(32'h8000_000C, B, E, 0);
      push_vec(32'h8000_0004, B, E, 1);
      drain("balanced");

      // Mismatched return; pop still happens so the stack ends empty.
      push_vec(32'h8000_0000, B, E, 0);
      push_vec(32'h8000_000C, B, E, 1);
      push_vec(32'h8000_0004, B, E, 1);
      // END is inclusive (RET slot at END, empty stack); START-4 is outside.
      push_vec(32'h8000_0024, B, E, 1);
      push_vec(32'h7FFF_FFFC, B, E, 0);
      drain("mismatch");

      // Same balanced stream with random FIFO stalls.
      stall_en = 1;
      push_vec(32'h8000_0008, B, E, 0);
      push_vec(32'h0000_1234, B, E, 0);
      push_vec(32'h8000_0010, B, E, 0);
      push_vec(32'h8000_0014, B, E, 0);
      push_vec(32'h8000_000C, B, E, 0);
      push_vec(32'h8000_0004, B, E, 1);
      drain("stalled");
      stall_en = 0;

      // Slot indices survive a START change, including across packets.
      push_vec(32'h8000_0010, B, E, 0);
      push_vec(32'h8000_0014, B, E, 0);
      push_vec(32'h8000_0050, B2, E2, 0);
      push_vec(32'h8000_0054, B2, E2, 0);
      push_vec(32'h8000_0008, B, E, 0);
      push_vec(32'h8000_004C, B2, E2, 0);
      push_vec(32'h8000_0044, B2, E2, 1);
      drain("start_change");

      // Overflow, misaligned target, beyond-END target, then full unwind.
      for (int i = 0; i < 33; i++)
         push_vec(B + 32'(8 * i), B, EB, (i == 32));
      push_vec(B + 32'h2, B, EB, 1);
      push_vec(EB + 32'h4, B, EB, 0);
      for (int i = 31; i >= 0; i--)
         push_vec(B + 32'(8 * i) + 32'h4, B, EB, 0);
      push_vec(B + 32'h4, B, EB, 1);
      drain("overflow");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
